pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Sequences the decode→execute pipeline register and its neighbours. Generates per-stage stall (hold) and flush (bubble) controls, and operand-forwarding selects for the execute stage.
- Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits, with a memory timeout watchdog.
- A flush into the decode→execute register zeroes it, so RWRITE and WE are cleared and the slot becomes a bubble.

Parameters:
- REG_W, 4, register-index width.
- PC_REG, 15, register index never forwarded and never checked for hazards.
- FETCH_LAT, 1, extra cycles flush_fd stays high after the branch cycle (instruction-memory latency); 0..7.
- MEM_TIMEOUT, 16, maximum consecutive memory-wait stall cycles before abort; ≥2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- id_valid  in  1  decode stage holds a real instruction.
- id_rn, id_rm  in  REG_W  source registers of the instruction in decode.
- ex_rn, ex_rm  in  REG_W  source registers of the instruction in execute.
- ex_rd  in  REG_W  destination of the instruction in execute.
- ex_rwrite  in  1  execute-stage instruction writes ex_rd.
- ex_load  in  1  execute-stage instruction reads memory (SelectMem path).
- branch_taken  in  1  branch resolved taken in execute.
- mem_rd  in  REG_W  destination in memory stage.
- mem_rwrite  in  1  memory-stage write enable.
- wb_rd  in  REG_W  destination in writeback stage.
- wb_rwrite  in  1  writeback-stage write enable.
- mem_req  in  1  memory stage has an outstanding access.
- mem_ready  in  1  data memory completes the access this cycle.
- stall_fd, stall_de, stall_em  out  1  hold fetch/decode, decode/execute and execute/memory registers.
- flush_fd, flush_de  out  1  clear fetch/decode and decode/execute registers.
- fwd_a, fwd_b  out  2  execute operand select: 00 register file, 10 memory-stage result, 01 writeback result.
- mem_err  out  1  sticky: a memory access timed out.
- stall_cnt, flush_cnt  out  32  performance counters (see Optional Feature).

Behaviour:
- Outputs are Mealy, combinational from state plus inputs; state updates on posedge clk.
- Reset (asynchronous): state=RUN, br_cnt=0, wait_cnt=0, mem_err=0, counters=0.
- Forwarding, combinational and independent of state, shown for operand A (operand B is identical using ex_rm):
  - fwd_a=10 if mem_rwrite && mem_rd==ex_rn && ex_rn!=PC_REG.
  - else fwd_a=01 if wb_rwrite && wb_rd==ex_rn && ex_rn!=PC_REG.
  - else fwd_a=00.
  - The memory stage wins when both stages match.
- mem_busy = mem_req && !mem_ready.
- timeout_hit = (wait_cnt == MEM_TIMEOUT).
- stall_mem = mem_busy && !timeout_hit.
- Priority, highest first:
  1. stall_mem: stall_fd=stall_de=stall_em=1, both flushes 0. State and br_cnt hold; wait_cnt increments.
  2. branch_taken: flush_fd=flush_de=1, no stalls.
     - If FETCH_LAT>0: next state BR_FLUSH, br_cnt=FETCH_LAT.
     - Else stay in RUN.
  3. State BR_FLUSH: flush_fd=1 only. br_cnt decrements; go to RUN when br_cnt reaches 1.
  4. Load-use (RUN only): condition is id_valid && ex_load && ex_rwrite && ex_rd!=PC_REG && (ex_rd==id_rn || ex_rd==id_rm).
     - Outputs: stall_fd=1, flush_de=1 for exactly that cycle.
  5. Otherwise all controls are 0.
- wait_cnt is cleared whenever mem_busy=0.
- On a cycle with mem_busy && timeout_hit:
  - Stalls are released; lower priorities are evaluated normally.
  - mem_err is set and stays set until reset.
  - wait_cnt is cleared.
- States: RUN, BR_FLUSH. "Waiting" is wait_cnt>0, not a separate state.
- Simultaneous events:
  - Branch and memory stall: the stall wins. The execute stage is held, so branch_taken is re-presented next cycle; nothing is latched.
  - Branch and load-use: the branch wins, because the decode instruction is wrong-path.
  - Branch while in BR_FLUSH: the count restarts at FETCH_LAT.
- Register-index compares use full REG_W width, with no sign or extension effects.

Optional Feature:
- Macro HAZ_PERFCNT_EN.
- Defined:
  - stall_cnt increments on every cycle with stall_fd=1.
  - flush_cnt increments on every cycle with flush_fd=1 or flush_de=1.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are inferred.

Test Plan:
- Forwarding, case 1: mem_rwrite=1, mem_rd=3, wb_rwrite=1, wb_rd=3, ex_rn=3 → fwd_a=10, fwd_b=00.
- Forwarding, case 2: ex_rn=15 with mem_rd=15 → fwd_a=00.
- Forwarding, case 3: only wb_rd=3 matches → fwd_a=01.
- Load-use: ex_load=1, ex_rwrite=1, ex_rd=5, id_rm=5, id_valid=1 for one cycle → stall_fd=1 and flush_de=1 for 1 cycle; next cycle, with ex_load=0, all controls are 0.
- Branch (FETCH_LAT=2): branch_taken pulse at cycle 0 →
  - cycle 0: flush_fd=flush_de=1;
  - cycles 1–2: flush_fd=1 only;
  - cycle 3: all 0;
  - flush_cnt=3 with the macro defined.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 → stall_fd/de/em=1 for 3 cycles, 0 on the ready cycle; stall_cnt=3; mem_err=0.
- Timeout (MEM_TIMEOUT=8): mem_req=1, mem_ready never asserted → stalls high for 8 cycles; 9th cycle stalls low and mem_err=1; mem_err stays 1 until reset.
- Reset: assert reset asynchronously mid-BR_FLUSH and mid-wait → all outputs 0 immediately, without waiting for a clock edge; after release, state is RUN and counters are 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush sequencing, operand forwarding and a memory-wait watchdog.
// Optional performance counters are built when HAZ_PERFCNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int REG_W       = 4,
    parameter int PC_REG      = 15,
    parameter int FETCH_LAT   = 1,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic [REG_W-1:0] ex_rn,
    input  logic [REG_W-1:0] ex_rm,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_rwrite,
    input  logic             ex_load,
    input  logic             branch_taken,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_rwrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_rwrite,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             stall_fd,
    output logic             stall_de,
    output logic             stall_em,
    output logic             flush_fd,
    output logic             flush_de,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_BR_FLUSH = 1'b1;

    localparam logic [REG_W-1:0]  PC_IDX   = REG_W'(PC_REG);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [2:0]        BR_LOAD  = 3'(FETCH_LAT);

    logic [0:0]        state_r;
    logic [0:0]        state_nxt_s;
    logic [2:0]        br_cnt_r;
    logic [2:0]        br_cnt_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_nxt_s;
    logic              mem_err_r;
    logic              err_set_s;

    logic              mem_busy_s;
    logic              timeout_hit_s;
    logic              stall_mem_s;
    logic              load_use_s;

    logic              stall_fd_s;
    logic              stall_de_s;
    logic              stall_em_s;
    logic              flush_fd_s;
    logic              flush_de_s;
    logic [1:0]        fwd_a_s;
    logic [1:0]        fwd_b_s;

    // Memory stage result takes precedence over writeback; the PC index is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic             m_we,
        input logic [REG_W-1:0] m_rd,
        input logic             w_we,
        input logic [REG_W-1:0] w_rd
    );
        logic [1:0] sel;
        if (src == PC_IDX) begin
            sel = 2'b00;
        end else if (m_we && (m_rd == src)) begin
            sel = 2'b10;
        end else if (w_we && (w_rd == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign mem_busy_s    = mem_req && !mem_ready;
    assign timeout_hit_s = (wait_cnt_r == WAIT_MAX);
    assign stall_mem_s   = mem_busy_s && !timeout_hit_s;
    assign load_use_s    = id_valid && ex_load && ex_rwrite && (ex_rd != PC_IDX) &&
                           ((ex_rd == id_rn) || (ex_rd == id_rm));
    assign fwd_a_s       = fwd_sel(ex_rn, mem_rwrite, mem_rd, wb_rwrite, wb_rd);
    assign fwd_b_s       = fwd_sel(ex_rm, mem_rwrite, mem_rd, wb_rwrite, wb_rd);

    // Watchdog: count consecutive busy cycles, abort the wait when the limit is reached.
    always_comb begin
        wait_cnt_nxt_s = wait_cnt_r;
        err_set_s      = 1'b0;
        if (!mem_busy_s) begin
            wait_cnt_nxt_s = {WAIT_W{1'b0}};
        end else if (timeout_hit_s) begin
            wait_cnt_nxt_s = {WAIT_W{1'b0}};
            err_set_s      = 1'b1;
        end else begin
            wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE;
        end
    end

    // Prioritised stall/flush decision and branch-flush sequencing.
    always_comb begin
        stall_fd_s   = 1'b0;
        stall_de_s   = 1'b0;
        stall_em_s   = 1'b0;
        flush_fd_s   = 1'b0;
        flush_de_s   = 1'b0;
        state_nxt_s  = state_r;
        br_cnt_nxt_s = br_cnt_r;
        if (stall_mem_s) begin
            stall_fd_s = 1'b1;
            stall_de_s = 1'b1;
            stall_em_s = 1'b1;
        end else if (branch_taken) begin
            flush_fd_s = 1'b1;
            flush_de_s = 1'b1;
            if (FETCH_LAT > 0) begin
                state_nxt_s  = ST_BR_FLUSH;
                br_cnt_nxt_s = BR_LOAD;
            end else begin
                state_nxt_s  = ST_RUN;
                br_cnt_nxt_s = 3'd0;
            end
        end else if (state_r == ST_BR_FLUSH) begin
            flush_fd_s = 1'b1;
            if (br_cnt_r <= 3'd1) begin
                state_nxt_s  = ST_RUN;
                br_cnt_nxt_s = 3'd0;
            end else begin
                br_cnt_nxt_s = br_cnt_r - 3'd1;
            end
        end else if ((state_r == ST_RUN) && load_use_s) begin
            stall_fd_s = 1'b1;
            flush_de_s = 1'b1;
        end else begin
            stall_fd_s = 1'b0;
            flush_de_s = 1'b0;
        end
    end

    // Control state, branch-flush counter, wait counter and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_RUN;
            br_cnt_r   <= 3'd0;
            wait_cnt_r <= {WAIT_W{1'b0}};
            mem_err_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            br_cnt_r   <= br_cnt_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            if (err_set_s) begin
                mem_err_r <= 1'b1;
            end
        end
    end

    // Outputs are forced quiet while reset is held so they drop without a clock edge.
    always_comb begin
        if (reset) begin
            stall_fd = 1'b0;
            stall_de = 1'b0;
            stall_em = 1'b0;
            flush_fd = 1'b0;
            flush_de = 1'b0;
            fwd_a    = 2'b00;
            fwd_b    = 2'b00;
            mem_err  = 1'b0;
        end else begin
            stall_fd = stall_fd_s;
            stall_de = stall_de_s;
            stall_em = stall_em_s;
            flush_fd = flush_fd_s;
            flush_de = flush_de_s;
            fwd_a    = fwd_a_s;
            fwd_b    = fwd_b_s;
            mem_err  = mem_err_r || err_set_s;
        end
    end

`ifdef HAZ_PERFCNT_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Saturating performance counters for stall and flush cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (stall_fd_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if ((flush_fd_s || flush_de_s) && (flush_cnt_r != 32'hFFFF_FFFF)) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (FETCH_LAT=2, MEM_TIMEOUT=8): directed vectors, queued expectations.
module tb_pipeline_hazard_ctrl;

`ifdef HAZ_PERFCNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // ctl = {stall_fd, stall_de, stall_em, flush_fd, flush_de, mem_err}
    localparam logic [5:0] Z      = 6'b000000;
    localparam logic [5:0] STALL3 = 6'b111000;
    localparam logic [5:0] FLBOTH = 6'b000110;
    localparam logic [5:0] FLFD   = 6'b000100;
    localparam logic [5:0] LU     = 6'b100010;
    localparam logic [5:0] ERR    = 6'b000001;

    typedef struct {
        string       name;
        logic [5:0]  ctl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        bit          chk_cnt;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, ex_rwrite, ex_load, branch_taken, mem_rwrite, wb_rwrite, mem_req, mem_ready;
    logic [3:0] id_rn, id_rm, ex_rn, ex_rm, ex_rd, mem_rd, wb_rd;
    logic       stall_fd, stall_de, stall_em, flush_fd, flush_de, mem_err;
    logic [1:0] fwd_a, fwd_b;
    logic [31:0] stall_cnt, flush_cnt;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_W(4), .PC_REG(15), .FETCH_LAT(2), .MEM_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd), .ex_rwrite(ex_rwrite), .ex_load(ex_load),
        .branch_taken(branch_taken), .mem_rd(mem_rd), .mem_rwrite(mem_rwrite), .wb_rd(wb_rd),
        .wb_rwrite(wb_rwrite), .mem_req(mem_req), .mem_ready(mem_ready),
        .stall_fd(stall_fd), .stall_de(stall_de), .stall_em(stall_em),
        .flush_fd(flush_fd), .flush_de(flush_de), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Monitor: one expectation per cycle, compared mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [9:0] got;
            logic [9:0] want;
            e    = exp_q.pop_front();
            got  = {stall_fd, stall_de, stall_em, flush_fd, flush_de, mem_err, fwd_a, fwd_b};
            want = {e.ctl, e.fa, e.fb};
            n_total++;
            if (got === want) n_pass++;
            else $display("FAIL %s ctl/fwd: got %b required %b", e.name, got, want);
            if (e.chk_cnt) begin
                n_total++;
                if (stall_cnt === e.sc) n_pass++;
                else $display("FAIL %s stall_cnt: got %0d required %0d", e.name, stall_cnt, e.sc);
                n_total++;
                if (flush_cnt === e.fc) n_pass++;
                else $display("FAIL %s flush_cnt: got %0d required %0d", e.name, flush_cnt, e.fc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_out(input string nm, input logic [5:0] ctl, input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        e.name = nm; e.ctl = ctl; e.fa = fa; e.fb = fb;
        e.chk_cnt = 1'b0; e.sc = 32'd0; e.fc = 32'd0;
        exp_q.push_back(e);
    endtask

    task automatic exp_cnt(input string nm, input logic [5:0] ctl, input int sc, input int fc);
        exp_t e;
        e.name = nm; e.ctl = ctl; e.fa = 2'b00; e.fb = 2'b00;
        e.chk_cnt = 1'b1;
        e.sc = PERF ? 32'(sc) : 32'd0;
        e.fc = PERF ? 32'(fc) : 32'd0;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        id_valid = 1'b0; ex_rwrite = 1'b0; ex_load = 1'b0; branch_taken = 1'b0;
        mem_rwrite = 1'b0; wb_rwrite = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        id_rn = 4'd0; id_rm = 4'd0; ex_rn = 4'd0; ex_rm = 4'd0; ex_rd = 4'd0;
        mem_rd = 4'd0; wb_rd = 4'd0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        exp_cnt("reset_state", Z, 0, 0);
        tick(); reset = 1'b0;
        exp_cnt("after_release", Z, 0, 0);

        // Forwarding
        tick(); mem_rwrite = 1'b1; mem_rd = 4'd3; wb_rwrite = 1'b1; wb_rd = 4'd3; ex_rn = 4'd3; ex_rm = 4'd0;
        exp_out("fwd_mem_wins", Z, 2'b10, 2'b00);
        tick(); mem_rd = 4'd15; wb_rd = 4'd15; ex_rn = 4'd15; ex_rm = 4'd15;
        exp_out("fwd_pc_never", Z, 2'b00, 2'b00);
        tick(); mem_rd = 4'd7; wb_rd = 4'd3; ex_rn = 4'd3; ex_rm = 4'd7;
        exp_out("fwd_wb_and_mem", Z, 2'b01, 2'b10);
        tick(); mem_rwrite = 1'b0; mem_rd = 4'd3; wb_rd = 4'd3; ex_rn = 4'd3; ex_rm = 4'd11;
        exp_out("fwd_mem_we_off", Z, 2'b01, 2'b00);
        tick(); mem_rwrite = 1'b1; wb_rwrite = 1'b0; mem_rd = 4'd3; ex_rn = 4'd11; ex_rm = 4'd3;
        exp_out("fwd_full_width", Z, 2'b00, 2'b10);

        // Load-use
        tick(); idle(); id_valid = 1'b1; ex_load = 1'b1; ex_rwrite = 1'b1; ex_rd = 4'd5; id_rm = 4'd5;
        exp_out("load_use", LU, 2'b00, 2'b00);
        tick(); ex_load = 1'b0;
        exp_cnt("load_use_after", Z, 1, 1);
        tick(); ex_load = 1'b1; ex_rd = 4'd15; id_rn = 4'd15; id_rm = 4'd15;
        exp_out("load_use_pc", Z, 2'b00, 2'b00);
        tick(); ex_rwrite = 1'b0; ex_rd = 4'd5; id_rn = 4'd5; id_rm = 4'd0;
        exp_out("load_use_no_write", Z, 2'b00, 2'b00);

        // Branch beats load-use, then FETCH_LAT=2 flush_fd cycles
        tick(); ex_rwrite = 1'b1; branch_taken = 1'b1;
        exp_cnt("branch_c0", FLBOTH, 1, 1);
        tick(); branch_taken = 1'b0;
        exp_out("branch_c1", FLFD, 2'b00, 2'b00);
        tick();
        exp_out("branch_c2", FLFD, 2'b00, 2'b00);
        tick(); idle();
        exp_cnt("branch_c3", Z, 1, 4);

        // Memory wait, branch held off by the stall
        tick(); mem_req = 1'b1; mem_ready = 1'b0;
        exp_out("memwait_1", STALL3, 2'b00, 2'b00);
        tick();
        exp_out("memwait_2", STALL3, 2'b00, 2'b00);
        tick(); branch_taken = 1'b1;
        exp_out("memwait_3_branch", STALL3, 2'b00, 2'b00);
        tick(); mem_ready = 1'b1;
        exp_cnt("memwait_ready_branch", FLBOTH, 4, 4);
        tick(); mem_req = 1'b0; mem_ready = 1'b0;
        exp_out("branch_restart", FLBOTH, 2'b00, 2'b00);
        tick(); branch_taken = 1'b0;
        exp_out("restart_c1", FLFD, 2'b00, 2'b00);
        tick();
        exp_out("restart_c2", FLFD, 2'b00, 2'b00);
        tick();
        exp_cnt("restart_done", Z, 4, 8);

        // Timeout after 8 stall cycles
        for (int i = 0; i < 8; i++) begin
            tick(); mem_req = 1'b1;
            exp_out($sformatf("timeout_stall_%0d", i), STALL3, 2'b00, 2'b00);
        end
        tick();
        exp_out("timeout_hit", ERR, 2'b00, 2'b00);
        tick();
        exp_cnt("timeout_restall", STALL3 | ERR, 12, 8);
        tick(); mem_req = 1'b0;
        exp_cnt("err_sticky", ERR, 13, 8);

        // Asynchronous reset mid-BR_FLUSH
        tick(); branch_taken = 1'b1;
        exp_out("pre_reset_branch", FLBOTH | ERR, 2'b00, 2'b00);
        tick(); branch_taken = 1'b0; reset = 1'b1;
        exp_cnt("reset_mid_brflush", Z, 0, 0);
        tick(); reset = 1'b0;
        exp_cnt("after_reset_run", Z, 0, 0);

        // Asynchronous reset mid-wait, then wait counter starts fresh
        tick(); mem_req = 1'b1;
        exp_out("wait_a", STALL3, 2'b00, 2'b00);
        tick();
        exp_out("wait_b", STALL3, 2'b00, 2'b00);
        tick(); reset = 1'b1;
        exp_cnt("reset_mid_wait", Z, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick(); reset = 1'b0;
            exp_out($sformatf("post_reset_stall_%0d", i), STALL3, 2'b00, 2'b00);
        end
        tick();
        exp_out("post_reset_timeout", ERR, 2'b00, 2'b00);
        tick(); mem_req = 1'b0;
        exp_cnt("post_reset_final", ERR, 8, 0);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
